// File: rtl/shift_delay_line.sv
// shift_delay_line: multi-word delay line with run-time tap, recirculation, zero fill, hold and fill tracking.
module shift_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             flush,
  input  logic             len_ld,
  input  logic [LW-1:0]    len_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [LW-1:0]    len_q
);
  localparam logic [1:0] SHIFT = 2'b00, RECIRC = 2'b01, ZERO_FILL = 2'b10, HOLD = 2'b11;
  if (DEPTH < 2 || DEPTH != (1 << LW)) begin : g_bad_depth
    $error("shift_delay_line: DEPTH must be a power of two >= 2");
  end
  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [LW:0]                 fcnt;
  logic [LW:0]                 full;
  logic [WIDTH-1:0]            fill;
  logic                        shift;
  logic                        count;
  always_comb begin
    full  = {1'b0, len_q} + (LW + 1)'(1);
    fill  = mode == RECIRC ? stage[len_q] : mode == ZERO_FILL ? '0 : din;
    shift = en && mode != HOLD;
    count = en && (mode == SHIFT || mode == ZERO_FILL) && fcnt != full;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage <= '0;
      fcnt  <= '0;
      len_q <= LW'(DEPTH - 1);
    end else begin
      stage <= flush ? '0 : shift ? {stage[DEPTH-2:0], fill} : stage;
      fcnt  <= (flush || len_ld) ? '0 : count ? fcnt + (LW + 1)'(1) : fcnt;
      if (len_ld) len_q <= len_in;
    end
  assign dout       = stage[len_q];
  assign dout_valid = fcnt == full;
endmodule

// File: tb/tb_shift_delay_line.sv
// tb_shift_delay_line: vector table, directed latency/tap/gap/reset sequences and random stimulus vs. an array model.
module tb_shift_delay_line;
  logic       clk, rst, en, flush, len_ld, dout_valid;
  logic [1:0] mode;
  logic [7:0] din, dout;
  logic [3:0] len_in, len_q;
  int total = 0, bad = 0;
  logic [7:0] m_st [16];
  int m_len, m_fc;
  typedef struct packed {
    logic       en;
    logic [1:0] mode;
    logic [7:0] din;
    logic       fl, ld;
    logic [3:0] li;
    logic [7:0] xd;
    logic       xv;
    logic [3:0] xl;
  } vec_t;
  vec_t tbl [17];
  shift_delay_line #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .flush(flush),
    .len_ld(len_ld), .len_in(len_in), .dout(dout), .dout_valid(dout_valid), .len_q(len_q)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic e, input logic [1:0] md, input logic [7:0] d, input logic fl,
                              input logic ld, input logic [3:0] li, input logic [7:0] xd, input logic xv,
                              input logic [3:0] xl);
    mk = {e, md, d, fl, ld, li, xd, xv, xl};
  endfunction
  task automatic model_reset();
    foreach (m_st[i]) m_st[i] = 8'h00;
    m_len = 15;
    m_fc = 0;
  endtask
  task automatic model_step(input logic e, input logic [1:0] md, input logic [7:0] d, input logic fl,
                            input logic ld, input logic [3:0] li);
    logic [7:0] nw;
    if (fl) foreach (m_st[i]) m_st[i] = 8'h00;
    else if (e && md != 2'd3) begin
      nw = md == 2'd1 ? m_st[m_len] : md == 2'd2 ? 8'h00 : d;
      for (int i = 15; i > 0; i--) m_st[i] = m_st[i-1];
      m_st[0] = nw;
    end
    if (fl || ld) m_fc = 0;
    else if (e && (md == 2'd0 || md == 2'd2) && m_fc < m_len + 1) m_fc++;
    if (ld) m_len = int'(li);
  endtask
  task automatic cyc(input logic e, input logic [1:0] md, input logic [7:0] d, input logic fl,
                     input logic ld, input logic [3:0] li);
    en = e; mode = md; din = d; flush = fl; len_ld = ld; len_in = li;
    @(posedge clk);
    model_step(e, md, d, fl, ld, li);
    #1;
    chk("mdl_dout", int'(dout), int'(m_st[m_len]));
    chk("mdl_valid", int'(dout_valid), int'(m_fc == m_len + 1));
    chk("mdl_len", int'(len_q), m_len);
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_len", int'(len_q), 15);
    rst = 0;
  endtask
  task automatic stream_latency(input int n);
    for (int k = 1; k <= n; k++) begin
      cyc(1, 2'd0, 8'(k), 0, 0, 0);
      chk("lat_dout", int'(dout), k >= 16 ? k - 15 : 0);
      chk("lat_valid", int'(dout_valid), int'(k >= 16));
    end
  endtask
  initial begin
    logic [7:0] words [64];
    int m;
    rst = 1; en = 0; mode = 0; din = 0; flush = 0; len_ld = 0; len_in = 0;
    do_reset();
    stream_latency(20);
    cyc(0, 2'd0, 8'h00, 0, 1, 4'd3);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 2'd0, 8'hA0 + 8'(k), 0, 0, 0);
      chk("tap_valid", int'(dout_valid), int'(k >= 3));
      if (k >= 3) chk("tap_dout", int'(dout), 'hA0 + k - 3);
    end
    cyc(0, 2'd0, 8'h00, 0, 1, 4'd3);
    m = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(k % 2 == 0, 2'd0, 8'hB0 + 8'(k), 0, 0, 0);
      if (k % 2 == 0) begin m++; words[m] = 8'hB0 + 8'(k); end
      chk("gap_valid", int'(dout_valid), int'(m >= 4));
      if (m >= 4) chk("gap_dout", int'(dout), int'(words[m-3]));
    end
    tbl[0]  = mk(0, 2'd0, 8'h00, 0, 1, 4'd3, 8'h00, 0, 4'd3);
    tbl[1]  = mk(1, 2'd0, 8'h11, 0, 0, 4'd0, 8'h00, 0, 4'd3);
    tbl[2]  = mk(1, 2'd0, 8'h22, 0, 0, 4'd0, 8'h00, 0, 4'd3);
    tbl[3]  = mk(1, 2'd0, 8'h33, 0, 0, 4'd0, 8'h00, 0, 4'd3);
    tbl[4]  = mk(1, 2'd0, 8'h44, 0, 0, 4'd0, 8'h11, 1, 4'd3);
    for (int i = 0; i < 8; i++)
      tbl[5+i] = mk(1, 2'd1, 8'hEE, 0, 0, 4'd0, 8'h22 + 8'h11 * 8'(i % 4) - ((i % 4 == 3) ? 8'h44 : 8'h00), 1, 4'd3);
    tbl[13] = mk(1, 2'd0, 8'h55, 0, 1, 4'd3, 8'h22, 0, 4'd3);
    tbl[14] = mk(1, 2'd0, 8'hFF, 1, 1, 4'd7, 8'h00, 0, 4'd7);
    tbl[15] = mk(1, 2'd3, 8'h77, 0, 0, 4'd0, 8'h00, 0, 4'd7);
    tbl[16] = mk(0, 2'd0, 8'h77, 0, 0, 4'd0, 8'h00, 0, 4'd7);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].en, tbl[i].mode, tbl[i].din, tbl[i].fl, tbl[i].ld, tbl[i].li);
      chk($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].xd));
      chk($sformatf("tbl%0d_valid", i), int'(dout_valid), int'(tbl[i].xv));
      chk($sformatf("tbl%0d_len", i), int'(len_q), int'(tbl[i].xl));
    end
    for (int k = 0; k < 3000; k++)
      cyc($urandom % 4 != 0, 2'($urandom), 8'($urandom), $urandom % 40 == 0, $urandom % 12 == 0,
          ($urandom % 2) ? 4'($urandom % 4) : 4'($urandom));
    do_reset();
    stream_latency(18);
    #2 rst = 1;
    #1;
    chk("arst_dout", int'(dout), 0);
    chk("arst_valid", int'(dout_valid), 0);
    chk("arst_len", int'(len_q), 15);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    stream_latency(18);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
